// File: rtl/dom_and_pipe_pkg.sv
// Shared constants and index helpers for the N-share DOM AND pipeline.
// Pair slices of r are enumerated (0,1),(0,2),...,(1,2),... in row order.
package dom_pkg;

    localparam int MAX_SHARES = 8;

    function automatic int nr(input int n);
        return n * (n - 1) / 2;
    endfunction

    // Requires i < j; maps the unordered share pair onto its r slice.
    function automatic int pair_idx(input int n, input int i, input int j);
        return i * n - i * (i + 1) / 2 + (j - i - 1);
    endfunction

    function automatic int share_lsb(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/dom_and_pipe_if.sv
// Operand/result bundle for dom_and_pipe: input handshake with masked operands
// and randomness, plus the output handshake carrying the result shares.
interface dom_and_pipe_if
    import dom_pkg::*;
#(
    parameter int N_SHARES = 2,
    parameter int WIDTH    = 1
) ();

    localparam int NR = nr(N_SHARES);

    logic                        in_valid;
    logic                        in_ready;
    logic [N_SHARES*WIDTH-1:0]   x;
    logic [N_SHARES*WIDTH-1:0]   y;
    logic [NR*WIDTH-1:0]         r;
    logic                        out_valid;
    logic                        out_ready;
    logic [N_SHARES*WIDTH-1:0]   z;

    modport master (
        output in_valid, x, y, r, out_ready,
        input  in_ready, out_valid, z
    );

    modport slave (
        input  in_valid, x, y, r, out_ready,
        output in_ready, out_valid, z
    );

endinterface

// File: rtl/dom_and_pipe_cross_reg.sv
// One share-domain register slice of the DOM integration stage. The domain tag
// identifies which (i,j) product term this register isolates for probing tools.
module dom_cross_reg
    import dom_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter int SHARE_DOMAIN = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (SHARE_DOMAIN < 0 || SHARE_DOMAIN >= MAX_SHARES * MAX_SHARES) begin : g_bad_domain
        $error("dom_cross_reg: share domain tag out of range");
    end

    (* share_domain = SHARE_DOMAIN *) logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/dom_and_pipe.sv
// WIDTH-bit, N_SHARES-share domain-oriented-masking AND with a valid/ready
// pipeline: registered integration stage, then XOR compression (optionally registered).
module dom_and_pipe
    import dom_pkg::*;
#(
    parameter int N_SHARES = 2,
    parameter int WIDTH    = 1,
    parameter bit REG_OUT  = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    dom_and_pipe_if.slave bus
);

    localparam int SW = N_SHARES * WIDTH;

    if (N_SHARES < 2 || N_SHARES > MAX_SHARES) begin : g_bad_shares
        $error("dom_and_pipe: N_SHARES must lie in 2..8");
    end

    logic [WIDTH-1:0] term [N_SHARES][N_SHARES];
    logic [WIDTH-1:0] t_q  [N_SHARES][N_SHARES];
    logic             s1_valid_reg;
    logic             s1_ready;
    logic             s1_load;
    logic             s2_ready;
    logic [SW-1:0]    comp;

    assign s1_ready    = !s1_valid_reg || s2_ready;
    assign s1_load     = bus.in_valid && s1_ready;
    assign bus.in_ready = s1_ready;

    // Cross terms (i,j) and (j,i) share one fresh mask so it cancels in the unmasked sum.
    for (genvar gi = 0; gi < N_SHARES; gi++) begin : g_row
        for (genvar gj = 0; gj < N_SHARES; gj++) begin : g_col
            if (gi == gj) begin : g_inner
                assign term[gi][gj] = bus.x[share_lsb(gi, WIDTH) +: WIDTH]
                                    & bus.y[share_lsb(gj, WIDTH) +: WIDTH];
            end else begin : g_cross
                localparam int K = pair_idx(N_SHARES, (gi < gj) ? gi : gj, (gi < gj) ? gj : gi);
                assign term[gi][gj] = (bus.x[share_lsb(gi, WIDTH) +: WIDTH]
                                     & bus.y[share_lsb(gj, WIDTH) +: WIDTH])
                                    ^ bus.r[K*WIDTH +: WIDTH];
            end

            dom_cross_reg #(
                .WIDTH        (WIDTH),
                .SHARE_DOMAIN (gi * N_SHARES + gj)
            ) u_cross_reg (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (s1_load),
                .d     (term[gi][gj]),
                .q     (t_q[gi][gj])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
        end else if (s1_ready) begin
            s1_valid_reg <= bus.in_valid;
        end
    end

    // Compression only ever combines registered terms.
    always_comb begin
        comp = '0;
        for (int i = 0; i < N_SHARES; i++) begin
            for (int j = 0; j < N_SHARES; j++) begin
                comp[i*WIDTH +: WIDTH] = comp[i*WIDTH +: WIDTH] ^ t_q[i][j];
            end
        end
    end

    if (REG_OUT) begin : g_reg_out
        logic          s2_valid_reg;
        logic [SW-1:0] z_reg;

        assign s2_ready = !s2_valid_reg || bus.out_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid_reg <= 1'b0;
                z_reg        <= '0;
            end else begin
                if (s2_ready) begin
                    s2_valid_reg <= s1_valid_reg;
                end
                if (s2_ready && s1_valid_reg) begin
                    z_reg <= comp;
                end
            end
        end

        assign bus.out_valid = s2_valid_reg;
        assign bus.z         = z_reg;
    end else begin : g_comb_out
        assign s2_ready      = bus.out_ready;
        assign bus.out_valid = s1_valid_reg;
        assign bus.z         = comp;
    end

endmodule

// File: tb/tb_dom_and_pipe.sv
// Scoreboard bench for dom_and_pipe: three configurations, randomized operands
// checked against a share-level model and the unmasked AND of the operands.
module tb_dom_and_pipe;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    dom_and_pipe_if #(.N_SHARES(3), .WIDTH(8)) a_if ();
    dom_and_pipe_if #(.N_SHARES(4), .WIDTH(4)) b_if ();
    dom_and_pipe_if #(.N_SHARES(2), .WIDTH(1)) c_if ();

    dom_and_pipe #(.N_SHARES(3), .WIDTH(8), .REG_OUT(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    dom_and_pipe #(.N_SHARES(4), .WIDTH(4), .REG_OUT(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if.slave));
    dom_and_pipe #(.N_SHARES(2), .WIDTH(1), .REG_OUT(1'b0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .bus(c_if.slave));

    logic        mon_v  [2];
    logic        mon_r  [2];
    logic        mon_ir [2];
    logic [63:0] mon_z  [2];
    assign mon_v[0]  = a_if.out_valid;
    assign mon_v[1]  = b_if.out_valid;
    assign mon_r[0]  = a_if.out_ready;
    assign mon_r[1]  = b_if.out_ready;
    assign mon_ir[0] = a_if.in_ready;
    assign mon_ir[1] = b_if.in_ready;
    assign mon_z[0]  = 64'(a_if.z);
    assign mon_z[1]  = 64'(b_if.z);

    typedef struct {
        logic [63:0] z;
        logic [63:0] u;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [63:0] b_last_z = '0;

    function automatic int ns(input int d);  return (d == 0) ? 3 : 4; endfunction
    function automatic int wd(input int d);  return (d == 0) ? 8 : 4; endfunction
    function automatic int lat(input int d); return (d == 0) ? 2 : 1; endfunction
    function automatic int qsize(input int d);
        return (d == 0) ? qa.size() : qb.size();
    endfunction

    // Reference: each share i is the XOR over j of x_i&y_j, with one fresh bit per unordered pair.
    function automatic logic [63:0] model_z(input int n, input int w, input logic [63:0] x,
                                            input logic [63:0] y, input logic [63:0] r);
        logic [63:0] z;
        logic        rb [8][8];
        logic        acc;
        int          k;
        z = '0;
        for (int b = 0; b < w; b++) begin
            k = 0;
            for (int i = 0; i < n; i++) begin
                for (int j = i + 1; j < n; j++) begin
                    rb[i][j] = r[k*w + b];
                    rb[j][i] = r[k*w + b];
                    k++;
                end
            end
            for (int i = 0; i < n; i++) begin
                acc = 1'b0;
                for (int j = 0; j < n; j++) begin
                    acc = acc ^ (x[i*w + b] & y[j*w + b]) ^ ((i != j) ? rb[i][j] : 1'b0);
                end
                z[i*w + b] = acc;
            end
        end
        return z;
    endfunction

    function automatic logic [63:0] unmask(input logic [63:0] v, input int n, input int w);
        logic [63:0] acc;
        logic [63:0] msk;
        acc = '0;
        msk = (64'd1 << w) - 64'd1;
        for (int i = 0; i < n; i++) acc = acc ^ ((v >> (i*w)) & msk);
        return acc;
    endfunction

    function automatic int pair_k(input int n, input int pi, input int pj);
        int k;
        k = 0;
        for (int i = 0; i < n; i++) begin
            for (int j = i + 1; j < n; j++) begin
                if (i == pi && j == pj) return k;
                k++;
            end
        end
        return -1;
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] r);
        if (d == 0) begin
            a_if.in_valid = v; a_if.x = 24'(x); a_if.y = 24'(y); a_if.r = 24'(r);
        end else begin
            b_if.in_valid = v; b_if.x = 16'(x); b_if.y = 16'(y); b_if.r = 24'(r);
        end
    endtask

    // Presents one operand until accepted; the expected result is queued at acceptance.
    task automatic send(input int d, input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] r, input bit push, input bit chk_lat);
        int   n;
        exp_t e;
        drive(d, 1'b1, x, y, r);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mon_ir[d] && n < 200);
        if (!mon_ir[d]) begin
            check_eq("accept_timeout", 64'(mon_ir[d]), 64'd1);
        end else if (push) begin
            e.z       = model_z(ns(d), wd(d), x, y, r);
            e.u       = unmask(x, ns(d), wd(d)) & unmask(y, ns(d), wd(d));
            e.acc     = cyc;
            e.chk_lat = chk_lat;
            if (d == 0) qa.push_back(e); else qb.push_back(e);
        end
        step();
        drive(d, 1'b0, x, y, r);
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_empty", 64'(qsize(d)), 64'd0);
        step();
    endtask

    function automatic logic [63:0] idle_sig();
        return {16'd0, a_if.z, b_if.z, c_if.z, a_if.out_valid, b_if.out_valid,
                c_if.out_valid, a_if.in_ready, b_if.in_ready, c_if.in_ready};
    endfunction

    // Monitor: pops the scoreboard on every output handshake and checks stall stability.
    initial begin
        bit          stalled [2];
        logic [63:0] stall_z [2];
        exp_t        e;
        int          diff;
        stalled[0] = 1'b0;
        stalled[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    stalled[d] = 1'b0;
                    continue;
                end
                if (stalled[d]) begin
                    check_eq("stall_z_hold", mon_z[d], stall_z[d]);
                    check_eq("stall_valid_hold", 64'(mon_v[d]), 64'd1);
                end
                if (mon_v[d] && mon_r[d]) begin
                    if (qsize(d) == 0) begin
                        check_eq("unexpected_output", 64'(qsize(d)), 64'd1);
                    end else begin
                        e = (d == 0) ? qa.pop_front() : qb.pop_front();
                        diff = cyc - e.acc;
                        check_eq("z_shares", mon_z[d], e.z);
                        check_eq("z_unmasked", unmask(mon_z[d], ns(d), wd(d)), e.u);
                        if (e.chk_lat) check_eq("latency", 64'(diff), 64'(lat(d)));
                        else check_eq("latency_min", 64'((diff >= lat(d)) ? lat(d) : diff), 64'(lat(d)));
                        if (d == 1) b_last_z = mon_z[d];
                        $display("txn dut=%0d z=%h unmasked=%h latency=%0d", d, mon_z[d],
                                 unmask(mon_z[d], ns(d), wd(d)), diff);
                    end
                end
                stalled[d] = mon_v[d] && !mon_r[d];
                stall_z[d] = mon_z[d];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] snap;
        logic [63:0] px, py, pr, z1, z2, m;
        int          toggles;
        int          c0;
        int          k;
        bit          b_done;

        rst_n = 1'b0;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        c_if.in_valid = 1'b0; c_if.x = '0; c_if.y = '0; c_if.r = '0;
        a_if.out_ready = 1'b1; b_if.out_ready = 1'b1; c_if.out_ready = 1'b1;
        repeat (2) step();

        check_eq("rst_a_out_valid", 64'(a_if.out_valid), 64'd0);
        check_eq("rst_a_z", 64'(a_if.z), 64'd0);
        check_eq("rst_a_in_ready", 64'(a_if.in_ready), 64'd1);
        check_eq("rst_b_out_valid", 64'(b_if.out_valid), 64'd0);
        check_eq("rst_b_z", 64'(b_if.z), 64'd0);
        check_eq("rst_c_in_ready", 64'(c_if.in_ready), 64'd1);
        rst_n = 1'b1;

        // Idle after reset: nothing observable may toggle.
        @(negedge clk);
        snap = idle_sig();
        toggles = 0;
        repeat (10) begin
            @(negedge clk);
            toggles += $countones(idle_sig() ^ snap);
            snap = idle_sig();
        end
        check_eq("idle_toggles", 64'(toggles), 64'd0);
        check_eq("idle_a_out_valid", 64'(a_if.out_valid), 64'd0);
        check_eq("idle_a_in_ready", 64'(a_if.in_ready), 64'd1);

        // Two-share single-bit example: x=1, y=1 unmasked.
        step();
        c_if.x = 2'b01; c_if.y = 2'b10; c_if.r = 1'b1; c_if.in_valid = 1'b1;
        @(negedge clk);
        check_eq("c_in_ready_accept", 64'(c_if.in_ready), 64'd1);
        step();
        c_if.in_valid = 1'b0;
        @(negedge clk);
        check_eq("c_out_valid", 64'(c_if.out_valid), 64'd1);
        check_eq("c_z", 64'(c_if.z), 64'd2);
        check_eq("c_in_ready_after", 64'(c_if.in_ready), 64'd1);
        @(negedge clk);
        check_eq("c_out_valid_drop", 64'(c_if.out_valid), 64'd0);

        // Back-to-back random stream with continuous out_ready.
        step();
        c0 = cyc;
        for (int i = 0; i < 1000; i++) begin
            send(0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1);
        end
        check_eq("a_throughput_cycles", 64'(cyc - c0), 64'd1000);
        drain(0);

        // Random gaps and random backpressure.
        b_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    send(1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
                end
                b_done = 1'b1;
            end
            begin
                while (!b_done) begin
                    step();
                    b_if.out_ready = ($urandom_range(0, 2) != 0);
                end
                b_if.out_ready = 1'b1;
            end
        join
        drain(1);

        // Flipping only the (1,3) randomness slice must move only shares 1 and 3.
        px = {$urandom, $urandom};
        py = {$urandom, $urandom};
        pr = {$urandom, $urandom};
        m  = 64'($urandom_range(1, 15));
        k  = pair_k(4, 1, 3);
        send(1, px, py, pr, 1'b1, 1'b1);
        drain(1);
        z1 = b_last_z;
        send(1, px, py, pr ^ (m << (k*4)), 1'b1, 1'b1);
        drain(1);
        z2 = b_last_z;
        check_eq("pair_r_diff", z1 ^ z2, (m << 4) | (m << 12));

        // Backpressure: two ops buffer, then the stall releases.
        a_if.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
                end
            end
            begin
                repeat (6) @(negedge clk);
                check_eq("bp_in_ready_low", 64'(a_if.in_ready), 64'd0);
                check_eq("bp_out_valid", 64'(a_if.out_valid), 64'd1);
                step();
                a_if.out_ready = 1'b1;
            end
        join
        drain(0);

        // Reset with a result in flight: it must vanish and never reappear.
        a_if.out_ready = 1'b0;
        send(0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        check_eq("mid_out_valid_before", 64'(a_if.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 64'(a_if.out_valid), 64'd0);
        check_eq("mid_rst_z", 64'(a_if.z), 64'd0);
        check_eq("mid_rst_in_ready", 64'(a_if.in_ready), 64'd1);
        check_eq("mid_rst_b_out_valid", 64'(b_if.out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        a_if.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_eq("post_rst_quiet", 64'(a_if.out_valid), 64'd0);
        end

        check_eq("final_qa_empty", 64'(qa.size()), 64'd0);
        check_eq("final_qb_empty", 64'(qb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
